// File: rtl/spi_pkg.sv
// Shared SPI definitions: word length, shift-direction encodings and receiver FSM states.
package spi_pkg;

    localparam int SPI_DATA_LENGTH = 8;
    localparam int SPI_MSB_FIRST   = 0;
    localparam int SPI_LSB_FIRST   = 1;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/spi_rx_if.sv
// Serial lines plus the received-word valid/ready handshake of the SPI receiver.
interface spi_rx_if #(
    parameter int DATA_LENGTH = 8
);
    logic                   mclk;
    logic                   ss_n;
    logic                   miso;
    logic [DATA_LENGTH-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic                   overrun;
    logic                   frame_err;

    modport master (
        output mclk, ss_n, miso, rx_ready,
        input  rx_data, rx_valid, overrun, frame_err
    );

    modport slave (
        input  mclk, ss_n, miso, rx_ready,
        output rx_data, rx_valid, overrun, frame_err
    );
endinterface

// File: rtl/spi_rx_fifo.sv
// Output FIFO for the SPI receiver; push while full is accepted only if a pop happens in the same cycle.
module spi_rx_fifo #(
    parameter int DATA_LENGTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [DATA_LENGTH-1:0] push_data_i,
    input  logic                   pop_i,
    output logic [DATA_LENGTH-1:0] head_data_o,
    output logic                   valid_o,
    output logic                   full_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_LENGTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_LENGTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [DATA_LENGTH-1:0] head_q, head_d;
    logic                   do_push;
    logic                   do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != FULL_CNT) || do_pop);

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Head is registered so the output keeps its last word once the FIFO drains.
        if (count_d != '0) begin
            head_d = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_data_o = head_q;
    assign valid_o     = (count_q != '0);
    assign full_o      = (count_q == FULL_CNT);

endmodule

// File: rtl/spi_rx.sv
// Mode-0 SPI receiver: synchronises MCLK/SS_N/MISO, deserialises words, flags aborted frames and overruns.
// Define SPI_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module spi_rx
    import spi_pkg::*;
#(
    parameter int DATA_LENGTH     = SPI_DATA_LENGTH,
    parameter int SHIFT_DIRECTION = SPI_MSB_FIRST,
    parameter int FIFO_DEPTH      = 4
) (
    input logic     clk,
    input logic     rst,
    spi_rx_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_LENGTH - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("spi_rx: FIFO_DEPTH must be a power of 2 >= 2");
    end

    logic [2:0]             mclk_sync_q, mclk_sync_d;
    logic [2:0]             ss_sync_q, ss_sync_d;
    logic [1:0]             miso_sync_q, miso_sync_d;
    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_LENGTH-1:0] shreg_q, shreg_d;
    logic [DATA_LENGTH-1:0] shifted;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   mclk_rise;
    logic                   ss_fall;
    logic                   ss_rise;
    logic                   miso_bit;
    logic                   push;
    logic                   pop;

    assign mclk_sync_d = {mclk_sync_q[1:0], bus.mclk};
    assign ss_sync_d   = {ss_sync_q[1:0], bus.ss_n};
    assign miso_sync_d = {miso_sync_q[0], bus.miso};

    assign mclk_rise = mclk_sync_q[1] & ~mclk_sync_q[2];
    assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
    assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
    assign miso_bit  = miso_sync_q[1];

    assign shifted = (SHIFT_DIRECTION == SPI_LSB_FIRST)
                   ? {miso_bit, shreg_q[DATA_LENGTH-1:1]}
                   : {shreg_q[DATA_LENGTH-2:0], miso_bit};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        push        = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (ss_fall) begin
                    state_d = RX_SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            RX_SHIFT: begin
                if (mclk_rise) begin
                    shreg_d = shifted;
                    if (cnt_q == LAST_BIT) begin
                        push  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // A bit arriving with the SS_N release is counted before judging the frame.
                if (ss_rise) begin
                    state_d     = RX_IDLE;
                    frame_err_d = (cnt_d != '0);
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pop = bus.rx_valid & bus.rx_ready;

`ifdef SPI_RX_FIFO_EN
    logic fifo_full;

    spi_rx_fifo #(
        .DATA_LENGTH (DATA_LENGTH),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (shifted),
        .pop_i       (pop),
        .head_data_o (bus.rx_data),
        .valid_o     (bus.rx_valid),
        .full_o      (fifo_full)
    );

    assign overrun_d = push & fifo_full & ~pop;
`else
    logic [DATA_LENGTH-1:0] hold_data_q, hold_data_d;
    logic                   hold_valid_q, hold_valid_d;

    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        overrun_d    = 1'b0;
        if (pop) begin
            hold_valid_d = 1'b0;
        end
        if (push) begin
            if (!hold_valid_q || pop) begin
                hold_data_d  = shifted;
                hold_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign bus.rx_data  = hold_data_q;
    assign bus.rx_valid = hold_valid_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mclk_sync_q <= 3'b000;
            ss_sync_q   <= 3'b111;
            miso_sync_q <= 2'b00;
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mclk_sync_q <= mclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            miso_sync_q <= miso_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: MSB-first and LSB-first receivers share one serial stream; words are predicted from the bit order.
module tb_spi_rx;
    import spi_pkg::*;

    localparam int FIFO_DEPTH = 4;
`ifdef SPI_RX_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic mclk     = 1'b0;
    logic ss_n     = 1'b1;
    logic miso     = 1'b0;
    logic rx_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] got_m[$], got_l[$], exp_m[$], exp_l[$];
    int ovr_m = 0, ovr_l = 0, ferr_m = 0, ferr_l = 0;
    int cyc = 0, last_rise_cyc = 0, valid_cyc = -1;
    logic valid_prev_m = 1'b0;

    always #5 clk = ~clk;

    spi_rx_if #(.DATA_LENGTH(8)) bus_m ();
    spi_rx_if #(.DATA_LENGTH(8)) bus_l ();

    assign bus_m.mclk = mclk;
    assign bus_m.ss_n = ss_n;
    assign bus_m.miso = miso;
    assign bus_m.rx_ready = rx_ready;
    assign bus_l.mclk = mclk;
    assign bus_l.ss_n = ss_n;
    assign bus_l.miso = miso;
    assign bus_l.rx_ready = rx_ready;

    spi_rx #(.DATA_LENGTH(8), .SHIFT_DIRECTION(SPI_MSB_FIRST), .FIFO_DEPTH(FIFO_DEPTH))
        u_dut_msb (.clk(clk), .rst(rst), .bus(bus_m));
    spi_rx #(.DATA_LENGTH(8), .SHIFT_DIRECTION(SPI_LSB_FIRST), .FIFO_DEPTH(FIFO_DEPTH))
        u_dut_lsb (.clk(clk), .rst(rst), .bus(bus_l));

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_m.rx_valid && rx_ready) got_m.push_back(bus_m.rx_data);
            if (bus_l.rx_valid && rx_ready) got_l.push_back(bus_l.rx_data);
            if (bus_m.overrun)   ovr_m++;
            if (bus_l.overrun)   ovr_l++;
            if (bus_m.frame_err) ferr_m++;
            if (bus_l.frame_err) ferr_l++;
            if (bus_m.rx_valid && !valid_prev_m && valid_cyc < 0) valid_cyc = cyc;
            valid_prev_m = bus_m.rx_valid;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Word value of a stream whose i-th transmitted bit is stream[7-i].
    function automatic logic [7:0] stream_value(input logic [7:0] stream, input bit lsb_first);
        int v = 0;
        for (int i = 0; i < 8; i++) begin
            if (stream[7-i]) v = v + (lsb_first ? (1 << i) : (1 << (7 - i)));
        end
        return v[7:0];
    endfunction

    task automatic clear_obs();
        @(posedge clk);
        got_m.delete(); got_l.delete(); exp_m.delete(); exp_l.delete();
        ovr_m = 0; ovr_l = 0; ferr_m = 0; ferr_l = 0;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 rx_ready = v;
    endtask

    task automatic frame_begin();
        @(negedge clk);
        ss_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        mclk = 1'b0;
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] stream, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mclk = 1'b0;
            miso = stream[7-i];
            repeat (3) @(negedge clk);
            @(negedge clk);
            mclk = 1'b1;
            last_rise_cyc = cyc;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [7:0] stream);
        send_bits(stream, 8);
        exp_m.push_back(stream_value(stream, 1'b0));
        exp_l.push_back(stream_value(stream, 1'b1));
    endtask

    task automatic check_words(input string tag);
        @(posedge clk);
        check_val({tag, "_cnt_msb"}, got_m.size(), exp_m.size());
        check_val({tag, "_cnt_lsb"}, got_l.size(), exp_l.size());
        for (int i = 0; i < exp_m.size() && i < got_m.size(); i++)
            check_val({tag, "_msb"}, got_m[i], exp_m[i]);
        for (int i = 0; i < exp_l.size() && i < got_l.size(); i++)
            check_val({tag, "_lsb"}, got_l[i], exp_l[i]);
    endtask

    task automatic check_flags(input string tag, input int exp_ovr, input int exp_ferr);
        check_val({tag, "_ovr_msb"},  ovr_m,  exp_ovr);
        check_val({tag, "_ovr_lsb"},  ovr_l,  exp_ovr);
        check_val({tag, "_ferr_msb"}, ferr_m, exp_ferr);
        check_val({tag, "_ferr_lsb"}, ferr_l, exp_ferr);
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_data_msb"},  bus_m.rx_data,   0);
        check_val({tag, "_valid_msb"}, bus_m.rx_valid,  0);
        check_val({tag, "_ovr_msb"},   bus_m.overrun,   0);
        check_val({tag, "_ferr_msb"},  bus_m.frame_err, 0);
        check_val({tag, "_data_lsb"},  bus_l.rx_data,   0);
        check_val({tag, "_valid_lsb"}, bus_l.rx_valid,  0);
    endtask

    initial begin
        int lat;
        int nw;

        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single word 0xA5 with latency measurement
        clear_obs();
        valid_cyc = -1;
        frame_begin();
        send_word(8'hA5);
        frame_end();
        lat = valid_cyc - last_rise_cyc;
        check_val("latency_in_range", (valid_cyc >= 0 && lat >= 3 && lat <= 4), 1);
        check_words("word_a5");
        check_flags("word_a5", 0, 0);

        // Two words in one frame
        clear_obs();
        frame_begin();
        send_word(8'h3C);
        send_word(8'hC3);
        frame_end();
        check_words("two_words");
        check_flags("two_words", 0, 0);

        // Stalled consumer: CAP words fit, the next one is dropped
        clear_obs();
        set_ready(1'b0);
        frame_begin();
        for (int i = 0; i <= CAP; i++) begin
            logic [7:0] w;
            w = 8'(8'h11 * (i + 1));
            send_bits(w, 8);
            if (i < CAP) begin
                exp_m.push_back(stream_value(w, 1'b0));
                exp_l.push_back(stream_value(w, 1'b1));
            end
        end
        frame_end();
        @(negedge clk);
        check_val("stall_valid", bus_m.rx_valid, 1);
        check_val("stall_head_msb", bus_m.rx_data, stream_value(8'h11, 1'b0));
        check_val("stall_head_lsb", bus_l.rx_data, stream_value(8'h11, 1'b1));
        check_flags("stall", 1, 0);
        set_ready(1'b1);
        repeat (CAP + 10) @(negedge clk);
        check_words("stall_drain");

        // Aborted frame after 5 bits, then a clean 0x7E frame
        clear_obs();
        frame_begin();
        send_bits(8'hB6, 5);
        frame_end();
        check_words("abort");
        check_flags("abort", 0, 1);
        clear_obs();
        frame_begin();
        send_word(8'h7E);
        frame_end();
        check_words("after_abort");
        check_flags("after_abort", 0, 0);

        // Reset in the middle of a word
        clear_obs();
        frame_begin();
        send_bits(8'hF0, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_cleared("mid_reset");
        mclk = 1'b0;
        ss_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        clear_obs();
        frame_begin();
        send_word(8'h81);
        frame_end();
        check_words("after_reset");
        check_flags("after_reset", 0, 0);

        // Stream 1,0,0,0,0,0,0,0: LSB-first receiver sees 0x01, MSB-first sees 0x80
        clear_obs();
        frame_begin();
        send_word(8'h80);
        frame_end();
        check_val("lsb_first_01", got_l.size() > 0 ? got_l[0] : 8'hxx, 8'h01);
        check_val("msb_first_80", got_m.size() > 0 ? got_m[0] : 8'hxx, 8'h80);

        // Randomized multi-word frames
        clear_obs();
        for (int f = 0; f < 15; f++) begin
            nw = $urandom_range(1, 3);
            frame_begin();
            for (int k = 0; k < nw; k++) send_word(8'($urandom_range(0, 255)));
            frame_end();
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        check_words("random");
        check_flags("random", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
